// File: rtl/full_adder_half_adder.sv
// Single-bit half adder: s = a ^ b, c = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder with a combinational result, a registered result qualified
// by in_valid, and a saturating count of accepted operations that carried out.
module full_adder #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  logic             ab_s;
  logic             ab_c;
  logic             sc_c;
  logic [CNT_W-1:0] carry_cnt_d;

  half_adder u_ha_ab (
    .a (a),
    .b (b),
    .s (ab_s),
    .c (ab_c)
  );

  half_adder u_ha_sc (
    .a (ab_s),
    .b (cin),
    .s (sum),
    .c (sc_c)
  );

  assign cout = ab_c | sc_c;

  // Stick at all-ones instead of wrapping back to zero.
  always_comb begin
    carry_cnt_d = carry_cnt;
    if (cout && (carry_cnt != '1)) begin
      carry_cnt_d = carry_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= 1'b0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
      carry_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q     <= sum;
        cout_q    <= cout;
        carry_cnt <= carry_cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: arithmetic reference model checked every
// cycle, plus directed literal checks; a CNT_W=2 copy exercises saturation.
module tb_full_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a = 1'b0;
  logic        b = 1'b0;
  logic        cin = 1'b0;
  logic        in_valid = 1'b0;

  logic        sum, cout, sum_q, cout_q, out_valid;
  logic [31:0] carry_cnt;
  logic        sum2, cout2, sum_q2, cout_q2, out_valid2;
  logic [1:0]  carry_cnt2;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit      model_live = 1'b0;
  bit      m_sum_q, m_cout_q, m_ov;
  longint  m_carries;

  always #5 clk = ~clk;

  full_adder #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q),
    .out_valid(out_valid), .carry_cnt(carry_cnt)
  );

  full_adder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum2), .cout(cout2), .sum_q(sum_q2), .cout_q(cout_q2),
    .out_valid(out_valid2), .carry_cnt(carry_cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint n, input int w);
    longint mx;
    mx = (64'sd1 <<< w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  always @(posedge clk) begin
    int total;
    total = int'(a) + int'(b) + int'(cin);
    if (rst) begin
      model_live = 1'b1;
      m_sum_q    = 1'b0;
      m_cout_q   = 1'b0;
      m_ov       = 1'b0;
      m_carries  = 0;
    end else if (model_live) begin
      m_ov = in_valid;
      if (in_valid) begin
        m_sum_q  = (total % 2) != 0;
        m_cout_q = (total / 2) != 0;
        if (total >= 2) m_carries++;
      end
    end
  end

  always @(negedge clk) begin
    int total;
    total = int'(a) + int'(b) + int'(cin);
    chk("comb_sum_cout", {62'd0, cout, sum}, 64'(total));
    chk("comb_sum_cout_w2", {62'd0, cout2, sum2}, 64'(total));
    if (model_live) begin
      chk("sum_q", 64'(sum_q), 64'(m_sum_q));
      chk("cout_q", 64'(cout_q), 64'(m_cout_q));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("carry_cnt", 64'(carry_cnt), 64'(sat(m_carries, 32)));
      chk("sum_q_w2", 64'(sum_q2), 64'(m_sum_q));
      chk("out_valid_w2", 64'(out_valid2), 64'(m_ov));
      chk("carry_cnt_w2", 64'(carry_cnt2), 64'(sat(m_carries, 2)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] v, input logic vld);
    {cin, b, a} = v;
    in_valid = vld;
    step();
  endtask

  initial begin
    logic [1:0] table_exp [8];
    table_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    // Exhaustive combinational table, offset from the clock edges
    #1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {cin, b, a} = v;
      #5;
      chk("exhaustive", 64'({cout, sum}), 64'(table_exp[i]));
    end

    step();
    step();
    chk("reset_sum_q", 64'(sum_q), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_cnt", 64'(carry_cnt), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    {cin, b, a} = 3'b000;
    step();

    // Registered latency
    {cin, b, a} = 3'b111;
    in_valid = 1'b1;
    #3;
    chk("lat_before_sum_q", 64'(sum_q), 64'd0);
    chk("lat_before_ov", 64'(out_valid), 64'd0);
    step();
    chk("lat_after_sum_q", 64'(sum_q), 64'd1);
    chk("lat_after_cout_q", 64'(cout_q), 64'd1);
    chk("lat_after_ov", 64'(out_valid), 64'd1);

    // Hold
    op(3'b000, 1'b0);
    chk("hold_sum_q", 64'(sum_q), 64'd1);
    chk("hold_cout_q", 64'(cout_q), 64'd1);
    chk("hold_ov", 64'(out_valid), 64'd0);

    // Counter: 5 carrying and 3 non-carrying ops, then one more carry
    rst = 1'b1;
    step();
    rst = 1'b0;
    op(3'b011, 1'b1); op(3'b000, 1'b1); op(3'b101, 1'b1); op(3'b001, 1'b1);
    op(3'b110, 1'b1); op(3'b010, 1'b1); op(3'b111, 1'b1); op(3'b011, 1'b1);
    chk("cnt_five", 64'(carry_cnt), 64'd5);
    chk("cnt_w2_sat5", 64'(carry_cnt2), 64'd3);
    op(3'b111, 1'b1);
    chk("cnt_six", 64'(carry_cnt), 64'd6);
    chk("cnt_w2_sat6", 64'(carry_cnt2), 64'd3);
    op(3'b111, 1'b0);
    chk("cnt_gated", 64'(carry_cnt), 64'd6);

    // Reset mid-run with a carrying op presented
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) op(3'b111, 1'b1);
    chk("mid_cnt4", 64'(carry_cnt), 64'd4);
    rst = 1'b1;
    in_valid = 1'b1;
    {cin, b, a} = 3'b111;
    #1;
    chk("mid_comb_in_rst", 64'({cout, sum}), 64'd3);
    step();
    chk("mid_cnt0", 64'(carry_cnt), 64'd0);
    chk("mid_ov0", 64'(out_valid), 64'd0);
    chk("mid_sum_q0", 64'(sum_q), 64'd0);
    rst = 1'b0;
    op(3'b110, 1'b1);
    chk("mid_first_after", 64'(carry_cnt), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    rst = 1'b0;
    in_valid = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
